axi_lite_master_ctrl: RTL and testbench
=======================================

AXI_LITE_MASTER_CTRL -- requirements
Module: axi_lite_master_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, meaning the maximum number of cycles spent waiting in any bus state before an abort (legal 2..255).
REQ-002 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a user command is present.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr, input, 3 bits: target address.
REQ-008 SHALL have port cmd_wdata, input, 4 bits: write data.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 4 bits: read data, valid with rsp_valid.
REQ-011 SHALL have port rsp_err, output, 1 bit: error or timeout, valid with rsp_valid.
REQ-012 SHALL have write-address channel ports: wa_addr out 3 bits, wa_valid out 1 bit, wa_ready in 1 bit.
REQ-013 SHALL have write-data channel ports: wd_data out 4 bits, wd_valid out 1 bit, wd_strb out 1 bit, wd_ready in 1 bit.
REQ-014 SHALL have write-response channel ports: b_valid in 1 bit, b_response in 1 bit (1 = OKAY), b_ready out 1 bit.
REQ-015 SHALL have read channel ports: ra_addr out 3 bits, ra_valid out 1 bit, ra_ready in 1 bit, rd_valid in 1 bit, rd_data in 4 bits, rd_ready out 1 bit.

Function
REQ-016 SHALL implement the FSM states IDLE, WRITE, WRESP, READ, RDATA and RESP, with all outputs registered.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready it SHALL latch addr, data and write flag, then go to WRITE (cmd_write=1) or READ (cmd_write=0).
REQ-018 SHALL, in WRITE, assert wa_valid and wd_valid in the same cycle with wd_strb=1, wa_addr equal to the latched address and wd_data equal to the latched data.
REQ-019 SHALL hold each valid and its payload stable until its own handshake (valid&ready at a clock edge), then deassert it.
REQ-020 SHALL track the address and data handshakes with independent done flags, so they may complete in either order or in the same cycle.
REQ-021 SHALL move from WRITE to WRESP when both done flags are set; b_ready=1 in WRESP only.
REQ-022 SHALL, on b_valid&b_ready, capture rsp_err = ~b_response and go to RESP.
REQ-023 SHALL, in READ, assert ra_valid with ra_addr equal to the latched address until ra_valid&ra_ready, then go to RDATA.
REQ-024 SHALL, in RDATA, assert rd_ready=1; on rd_valid&rd_ready it SHALL capture rd_data into rsp_rdata with rsp_err=0 and go to RESP.
REQ-025 SHALL, in RESP, assert rsp_valid for exactly 1 cycle, then return to IDLE.
REQ-026 SHALL hold rsp_rdata and rsp_err until the next RESP; rsp_rdata SHALL be 0 for writes.
REQ-027 SHALL clear the wait counter on entry to WRITE, WRESP, READ and RDATA, and increment it each cycle in those states.
REQ-028 SHALL, if the counter reaches TIMEOUT_CYC-1 without the state's completing handshake, deassert all bus valids/readies, set rsp_err=1 and rsp_rdata=0, and go to RESP.
REQ-029 SHALL give a completing handshake in the same cycle as the timeout priority over the timeout.
REQ-030 SHALL ignore b_valid outside WRESP and rd_valid outside RDATA; no state change and no capture.
REQ-031 SHALL, against a slave with all readies tied high and one-cycle responses, achieve write latency of 3 cycles and read latency of 3 cycles from cmd accept edge to rsp_valid.
REQ-032 SHALL ignore cmd_valid while not in IDLE, with only one outstanding transaction at a time.

Reset
REQ-033 SHALL, on reset_n=0 at any time including mid-transaction, go to IDLE asynchronously with cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all addr/data outputs=0, all valids/readies/strb=0, done flags=0 and counter=0.
REQ-034 SHALL drive cmd_ready=1 on the first clock edge after reset_n deasserts.

Verification
REQ-035 SHALL be verified with: write addr=5 data=0xA to an always-ready slave with b_response=1 -> wa/wd handshake in the same cycle, rsp_valid pulse, rsp_err=0.
REQ-036 SHALL be verified with: write with wd_ready delayed 3 cycles after wa_ready -> wd_valid held with 0xA stable, b_ready asserted only after both handshakes.
REQ-037 SHALL be verified with: read addr=2 with slave returning rd_data=0x6 after 2 cycles -> rsp_rdata=0x6, rsp_err=0.
REQ-038 SHALL be verified with: write to a slave that never asserts b_valid -> rsp_valid with rsp_err=1 after TIMEOUT_CYC cycles in WRESP, b_ready dropped.
REQ-039 SHALL be verified with: b_response=0 -> rsp_err=1; a spurious b_valid in IDLE -> no rsp_valid.
REQ-040 SHALL be verified with: reset_n pulsed low while in RDATA -> all outputs 0 immediately, then cmd_ready=1 and a following read completes normally.

Source files
------------

// File: rtl/axi_lite_master_ctrl.sv
// AXI-Lite style single-outstanding master: turns one user command into a
// write (AW/W/B) or read (AR/R) bus transaction with a per-state wait timeout.
module axi_lite_master_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_addr,
  input  logic [3:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [3:0] rsp_rdata,
  output logic       rsp_err,
  output logic [2:0] wa_addr,
  output logic       wa_valid,
  input  logic       wa_ready,
  output logic [3:0] wd_data,
  output logic       wd_valid,
  output logic       wd_strb,
  input  logic       wd_ready,
  input  logic       b_valid,
  input  logic       b_response,
  output logic       b_ready,
  output logic [2:0] ra_addr,
  output logic       ra_valid,
  input  logic       ra_ready,
  input  logic       rd_valid,
  input  logic [3:0] rd_data,
  output logic       rd_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_READ  = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_wa_done;
  logic       r_wd_done;
  logic [7:0] r_cnt;

  logic w_accept;
  logic w_wa_hs;
  logic w_wd_hs;
  logic w_b_hs;
  logic w_ra_hs;
  logic w_rd_hs;
  logic w_wa_done;
  logic w_wd_done;
  logic w_timeout;
  logic w_busy;

  assign w_accept  = cmd_valid & cmd_ready;
  assign w_wa_hs   = wa_valid & wa_ready;
  assign w_wd_hs   = wd_valid & wd_ready;
  assign w_b_hs    = (r_state == S_WRESP) & b_valid & b_ready;
  assign w_ra_hs   = ra_valid & ra_ready;
  assign w_rd_hs   = (r_state == S_RDATA) & rd_valid & rd_ready;
  // Done flags include this cycle's handshake so both channels may finish together.
  assign w_wa_done = (r_state == S_WRITE) & (r_wa_done | w_wa_hs);
  assign w_wd_done = (r_state == S_WRITE) & (r_wd_done | w_wd_hs);
  assign w_timeout = (r_cnt == TO_LAST);
  assign w_busy    = (r_state == S_WRITE) | (r_state == S_WRESP) |
                     (r_state == S_READ)  | (r_state == S_RDATA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_wa_done <= 1'b0;
      r_wd_done <= 1'b0;
      r_cnt     <= 8'd0;
    end else begin
      r_state   <= w_next;
      r_wa_done <= w_wa_done & (w_next == S_WRITE);
      r_wd_done <= w_wd_done & (w_next == S_WRITE);
      if (w_next != r_state) r_cnt <= 8'd0;
      else if (w_busy)       r_cnt <= r_cnt + 8'd1;
      else                   r_cnt <= 8'd0;
    end
  end

  // A completing handshake is tested before the timeout so it always wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = cmd_write ? S_WRITE : S_READ;
      S_WRITE: begin
        if (w_wa_done & w_wd_done) w_next = S_WRESP;
        else if (w_timeout)        w_next = S_RESP;
      end
      S_WRESP: if (w_b_hs | w_timeout)  w_next = S_RESP;
      S_READ: begin
        if (w_ra_hs)        w_next = S_RDATA;
        else if (w_timeout) w_next = S_RESP;
      end
      S_RDATA: if (w_rd_hs | w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one
  // changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 4'd0;
      rsp_err   <= 1'b0;
      wa_addr   <= 3'd0;
      wa_valid  <= 1'b0;
      wd_data   <= 4'd0;
      wd_valid  <= 1'b0;
      wd_strb   <= 1'b0;
      b_ready   <= 1'b0;
      ra_addr   <= 3'd0;
      ra_valid  <= 1'b0;
      rd_ready  <= 1'b0;
    end else begin
      cmd_ready <= (w_next == S_IDLE);
      wa_valid  <= (w_next == S_WRITE) & ~w_wa_done;
      wd_valid  <= (w_next == S_WRITE) & ~w_wd_done;
      wd_strb   <= (w_next == S_WRITE) & ~w_wd_done;
      b_ready   <= (w_next == S_WRESP);
      ra_valid  <= (w_next == S_READ);
      rd_ready  <= (w_next == S_RDATA);
      rsp_valid <= (w_next == S_RESP);
      if (w_accept & cmd_write) begin
        wa_addr <= cmd_addr;
        wd_data <= cmd_wdata;
      end
      if (w_accept & ~cmd_write) ra_addr <= cmd_addr;
      if (w_next == S_RESP) begin
        if (w_b_hs) begin
          rsp_err   <= ~b_response;
          rsp_rdata <= 4'd0;
        end else if (w_rd_hs) begin
          rsp_err   <= 1'b0;
          rsp_rdata <= rd_data;
        end else begin
          rsp_err   <= 1'b1;
          rsp_rdata <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Directed bench for axi_lite_master_ctrl: the bench plays the bus slave by hand
// and checks every output against hand-computed values one edge at a time.
module tb_axi_lite_master_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_write;
  logic [2:0] cmd_addr;
  logic [3:0] cmd_wdata;
  logic       cmd_ready;
  logic       rsp_valid, rsp_err;
  logic [3:0] rsp_rdata;
  logic [2:0] wa_addr, ra_addr;
  logic       wa_valid, wa_ready;
  logic [3:0] wd_data, rd_data;
  logic       wd_valid, wd_strb, wd_ready;
  logic       b_valid, b_response, b_ready;
  logic       ra_valid, ra_ready;
  logic       rd_valid, rd_ready;

  int n_vec = 0;
  int n_mis = 0;

  axi_lite_master_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wa_addr(wa_addr), .wa_valid(wa_valid), .wa_ready(wa_ready),
    .wd_data(wd_data), .wd_valid(wd_valid), .wd_strb(wd_strb), .wd_ready(wd_ready),
    .b_valid(b_valid), .b_response(b_response), .b_ready(b_ready),
    .ra_addr(ra_addr), .ra_valid(ra_valid), .ra_ready(ra_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] all_out();
    return {cmd_ready, rsp_valid, rsp_rdata, rsp_err, wa_addr, wa_valid, wd_data,
            wd_valid, wd_strb, b_ready, ra_addr, ra_valid, rd_ready};
  endfunction

  task automatic issue(input logic wr, input logic [2:0] a, input logic [3:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    wa_ready = 0; wd_ready = 0; b_valid = 0; b_response = 0;
    ra_ready = 0; rd_valid = 0; rd_data = 0;
    #1;
    chk("rst_outputs", 32'(all_out()), 32'h0);
    repeat (2) tick();
    chk("rst_cmd_ready_held", 32'(cmd_ready), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'h1);

    // Write addr 5 / data A, slave always ready, one-cycle B response.
    wa_ready = 1; wd_ready = 1;
    issue(1'b1, 3'd5, 4'hA);
    chk("wr1_valids", 32'({wa_valid, wd_valid, wd_strb, cmd_ready}), 32'b1110);
    chk("wr1_payload", 32'({wa_addr, wd_data}), 32'h5A);
    tick();
    chk("wr1_both_hs", 32'({wa_valid, wd_valid, b_ready}), 32'b001);
    b_valid = 1; b_response = 1;
    tick();
    b_valid = 0;
    chk("wr1_rsp", 32'({rsp_valid, rsp_err, rsp_rdata, b_ready}), 32'b1_0_0000_0);
    tick();
    chk("wr1_rsp_pulse", 32'({rsp_valid, cmd_ready}), 32'b01);

    // Write with W handshake 3 cycles after AW; a busy-time command must be ignored.
    wd_ready = 0;
    issue(1'b1, 3'd5, 4'hA);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd7; cmd_wdata = 4'h3;
    tick();
    chk("wr2_aw_done", 32'({wa_valid, wd_valid, wd_data, b_ready}), 32'b0_1_1010_0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wr2_wd_held", 32'({wa_valid, wd_valid, wd_strb, wd_data, wa_addr, b_ready}),
          32'b0_1_1_1010_101_0);
    end
    wd_ready = 1;
    tick();
    cmd_valid = 0;
    chk("wr2_wd_done", 32'({wd_valid, b_ready, ra_valid}), 32'b010);
    b_valid = 1; b_response = 1;
    tick();
    b_valid = 0;
    chk("wr2_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
    tick();

    // Read addr 2, data 6 returned two cycles after the address handshake.
    ra_ready = 1;
    issue(1'b0, 3'd2, 4'h0);
    chk("rd1_ar", 32'({ra_valid, ra_addr, wa_valid}), 32'b1_010_0);
    tick();
    chk("rd1_ar_done", 32'({ra_valid, rd_ready}), 32'b01);
    tick();
    chk("rd1_wait", 32'({rd_ready, rsp_valid}), 32'b10);
    rd_valid = 1; rd_data = 4'h6;
    tick();
    rd_valid = 0;
    chk("rd1_rsp", 32'({rsp_valid, rsp_err, rsp_rdata, rd_ready}), 32'b1_0_0110_0);
    tick();
    chk("rd1_idle", 32'({rsp_valid, cmd_ready}), 32'b01);

    // B never arrives: timeout after TO cycles in WRESP.
    issue(1'b1, 3'd1, 4'h4);
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("to_wait", 32'({b_ready, rsp_valid}), 32'b10);
    end
    tick();
    chk("to_rsp", 32'({rsp_valid, rsp_err, rsp_rdata, b_ready}), 32'b1_1_0000_0);
    tick();

    // B arriving on the timeout edge wins over the timeout.
    issue(1'b1, 3'd1, 4'h4);
    tick();
    repeat (TO - 1) tick();
    b_valid = 1; b_response = 1;
    tick();
    b_valid = 0;
    chk("to_prio_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
    tick();

    // SLVERR response, then stray B/R beats while idle.
    issue(1'b1, 3'd6, 4'hC);
    tick();
    b_valid = 1; b_response = 0;
    tick();
    chk("berr_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'b1_1_0000);
    rd_valid = 1; rd_data = 4'hF;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spurious_idle", 32'({rsp_valid, rsp_err, rsp_rdata, cmd_ready}), 32'b0_1_0000_1);
    end
    b_valid = 0; rd_valid = 0; rd_data = 0;

    // Asynchronous reset while waiting in RDATA, then a clean read.
    issue(1'b0, 3'd3, 4'h0);
    tick();
    chk("rst_mid_rdata", 32'(rd_ready), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'(all_out()), 32'h0);
    tick();
    reset_n = 1'b1;
    chk("rst_mid_cmd_ready0", 32'(cmd_ready), 32'h0);
    tick();
    chk("rst_mid_cmd_ready1", 32'(cmd_ready), 32'h1);
    issue(1'b0, 3'd4, 4'h0);
    chk("rd2_ar", 32'({ra_valid, ra_addr}), 32'b1_100);
    tick();
    rd_valid = 1; rd_data = 4'h9;
    tick();
    rd_valid = 0;
    chk("rd2_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'b1_0_1001);
    tick();
    chk("rd2_idle", 32'({rsp_valid, cmd_ready}), 32'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
